vga_driver: RTL and testbench

VGA_DRIVER -- requirements
Module: vga_driver

---
 rtl/vga_driver.sv | 92 +++++++++
 tb/tb_vga_driver.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_driver.sv
// VGA timing generator with a one-clock pixel request pipeline.
// Counters, syncs, the active window and the pixel request all derive from h_cnt/v_cnt.
module vga_driver #(
    parameter logic [11:0] H_SYNC  = 12'd120,
    parameter logic [11:0] H_BACK  = 12'd64,
    parameter logic [11:0] H_DISP  = 12'd800,
    parameter logic [11:0] H_TOTAL = 12'd1040,
    parameter logic [11:0] V_SYNC  = 12'd6,
    parameter logic [11:0] V_BACK  = 12'd23,
    parameter logic [11:0] V_DISP  = 12'd600,
    parameter logic [11:0] V_TOTAL = 12'd666
) (
    input  logic        clk_vga,
    input  logic        rst_n_vga,
    input  logic [15:0] pixel_data,
    output logic        data_req,
    output logic [11:0] xpos_vga,
    output logic [11:0] ypos_vga,
    output logic        hsync_vga,
    output logic        vsync_vga,
    output logic        data_en,
    output logic [15:0] rgb_vga,
    output logic        frame_start
);

    localparam logic [11:0] H_ACT_START = H_SYNC + H_BACK;
    localparam logic [11:0] H_ACT_END   = H_ACT_START + H_DISP;
    localparam logic [11:0] H_REQ_START = H_ACT_START - 12'd1;
    localparam logic [11:0] H_REQ_END   = H_ACT_END - 12'd1;
    localparam logic [11:0] V_ACT_START = V_SYNC + V_BACK;
    localparam logic [11:0] V_ACT_END   = V_ACT_START + V_DISP;

    logic [11:0] h_cnt;
    logic [11:0] v_cnt;
    logic        h_last;
    logic        v_last;
    logic        h_active;
    logic        h_req;
    logic        v_active;

    assign h_last = (h_cnt == H_TOTAL - 12'd1);
    assign v_last = (v_cnt == V_TOTAL - 12'd1);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_vga or negedge rst_n_vga) begin
        if (!rst_n_vga) begin
            h_cnt       <= 12'd0;
            v_cnt       <= 12'd0;
            frame_start <= 1'b0;
        end else begin
            h_cnt       <= h_last ? 12'd0 : h_cnt + 12'd1;
            frame_start <= h_last && v_last;
            if (h_last) begin
                v_cnt <= v_last ? 12'd0 : v_cnt + 12'd1;
            end
        end
    end

    // Request window is the active window shifted one clock earlier, so the
    // registered pixel from the generator lands exactly on data_en.
    always_comb begin
        // NOTE: every output gets a default first so no latch can be inferred.
        h_active  = 1'b0;
        h_req     = 1'b0;
        v_active  = 1'b0;
        data_req  = 1'b0;
        data_en   = 1'b0;
        xpos_vga  = 12'd0;
        ypos_vga  = 12'd0;
        hsync_vga = 1'b1;
        vsync_vga = 1'b1;
        rgb_vga   = 16'd0;

        h_active = (h_cnt >= H_ACT_START) && (h_cnt < H_ACT_END);
        h_req    = (h_cnt >= H_REQ_START) && (h_cnt < H_REQ_END);
        v_active = (v_cnt >= V_ACT_START) && (v_cnt < V_ACT_END);

        hsync_vga = (h_cnt >= H_SYNC);
        vsync_vga = (v_cnt >= V_SYNC);
        data_en   = h_active && v_active;
        data_req  = h_req && v_active;

        if (data_req) begin
            xpos_vga = h_cnt - H_REQ_START;
            ypos_vga = v_cnt - V_ACT_START;
        end
        if (data_en) begin
            rgb_vga = pixel_data;
        end
    end

endmodule

// File: tb/tb_vga_driver.sv
// Bench for vga_driver: a small-timing instance checked by table, scoreboard and reset
// sequences, plus a default-timing instance checked on hsync/vsync and the first active line.
module tb_vga_driver;

    localparam int HT = 20;
    localparam int VT = 12;
    localparam int FRAME = HT * VT;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // small-timing instance
    logic        rst_s;
    logic [15:0] pix_s;
    logic        req_s, hs_s, vs_s, en_s, fs_s;
    logic [11:0] x_s, y_s;
    logic [15:0] rgb_s;

    vga_driver #(
        .H_SYNC(12'd4), .H_BACK(12'd3), .H_DISP(12'd10), .H_TOTAL(12'd20),
        .V_SYNC(12'd2), .V_BACK(12'd2), .V_DISP(12'd5), .V_TOTAL(12'd12)
    ) u_small (
        .clk_vga(clk), .rst_n_vga(rst_s), .pixel_data(pix_s),
        .data_req(req_s), .xpos_vga(x_s), .ypos_vga(y_s),
        .hsync_vga(hs_s), .vsync_vga(vs_s), .data_en(en_s),
        .rgb_vga(rgb_s), .frame_start(fs_s)
    );

    // default-timing instance
    logic        rst_d;
    logic [15:0] pix_d;
    logic        req_d, hs_d, vs_d, en_d, fs_d;
    logic [11:0] x_d, y_d;
    logic [15:0] rgb_d;

    vga_driver u_dflt (
        .clk_vga(clk), .rst_n_vga(rst_d), .pixel_data(pix_d),
        .data_req(req_d), .xpos_vga(x_d), .ypos_vga(y_d),
        .hsync_vga(hs_d), .vsync_vga(vs_d), .data_en(en_d),
        .rgb_vga(rgb_d), .frame_start(fs_d)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    int cyc_d = 0;
    bit mon_en    = 1'b0;
    bit const_pix = 1'b0;
    logic [15:0] sb[$];

    typedef struct {
        int          h;
        int          v;
        logic        req;
        logic [11:0] x;
        logic [11:0] y;
        logic        hs;
        logic        vs;
        logic        en;
    } vec_t;

    vec_t vecs[14];

    function automatic logic [15:0] pix(input logic [11:0] x, input logic [11:0] y);
        return 16'hA500 ^ {4'h0, x ^ y};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input bit dflt, input int target);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (((dflt ? cyc_d : cyc) != target) && n < 40000);
        if ((dflt ? cyc_d : cyc) != target) begin
            n_vec++;
            n_err++;
            $display("FAIL wait_cyc: reached %0d expected %0d", dflt ? cyc_d : cyc, target);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " hsync"}, 32'(hs_s), 32'd0);
        check({tag, " vsync"}, 32'(vs_s), 32'd0);
        check({tag, " data_req"}, 32'(req_s), 32'd0);
        check({tag, " data_en"}, 32'(en_s), 32'd0);
        check({tag, " xpos"}, 32'(x_s), 32'd0);
        check({tag, " ypos"}, 32'(y_s), 32'd0);
        check({tag, " rgb"}, 32'(rgb_s), 32'd0);
        check({tag, " frame_start"}, 32'(fs_s), 32'd0);
    endtask

    // Position counters: number of rising edges seen since reset release.
    always @(posedge clk) cyc   <= rst_s ? cyc + 1 : 0;
    always @(posedge clk) cyc_d <= rst_d ? cyc_d + 1 : 0;

    // Pixel generator: registers the requested pixel once; 16'hDEAD exposes blanking leakage.
    always @(posedge clk) begin
        if (const_pix)  pix_s <= 16'hFFFF;
        else if (req_s) pix_s <= pix(x_s, y_s);
        else            pix_s <= 16'hDEAD;
    end

    // Scoreboard monitor for the small instance.
    always @(negedge clk) begin
        int h, v;
        logic ereq, een;
        logic [15:0] exp_pix;
        if (mon_en) begin
            h = cyc % HT;
            v = (cyc / HT) % VT;
            ereq = (v >= 4 && v < 9 && h >= 6 && h < 16);
            een  = (v >= 4 && v < 9 && h >= 7 && h < 17);
            check($sformatf("data_req c%0d", cyc), 32'(req_s), 32'(ereq));
            check($sformatf("data_en c%0d", cyc), 32'(en_s), 32'(een));
            check($sformatf("hsync c%0d", cyc), 32'(hs_s), 32'(h >= 4));
            check($sformatf("vsync c%0d", cyc), 32'(vs_s), 32'(v >= 2));
            check($sformatf("frame_start c%0d", cyc), 32'(fs_s), 32'(cyc != 0 && h == 0 && v == 0));
            check($sformatf("xpos c%0d", cyc), 32'(x_s), ereq ? 32'(h - 6) : 32'd0);
            check($sformatf("ypos c%0d", cyc), 32'(y_s), ereq ? 32'(v - 4) : 32'd0);
            if (een) begin
                if (sb.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL scoreboard empty c%0d: got rgb %0h expected a queued pixel", cyc, rgb_s);
                end else begin
                    exp_pix = sb.pop_front();
                    check($sformatf("rgb c%0d", cyc), 32'(rgb_s), 32'(exp_pix));
                end
            end else begin
                check($sformatf("rgb blank c%0d", cyc), 32'(rgb_s), 32'd0);
            end
            if (ereq) sb.push_back(const_pix ? 16'hFFFF : pix(12'(h - 6), 12'(v - 4)));
        end
    end

    initial begin
        int rise1, rise2, fall, n_white, n_zero;
        logic prev;

        vecs[0]  = '{3, 0, 1'b0, 12'd0, 12'd0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{4, 0, 1'b0, 12'd0, 12'd0, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{19, 1, 1'b0, 12'd0, 12'd0, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{0, 2, 1'b0, 12'd0, 12'd0, 1'b0, 1'b1, 1'b0};
        vecs[4]  = '{6, 4, 1'b1, 12'd0, 12'd0, 1'b1, 1'b1, 1'b0};
        vecs[5]  = '{7, 4, 1'b1, 12'd1, 12'd0, 1'b1, 1'b1, 1'b1};
        vecs[6]  = '{15, 4, 1'b1, 12'd9, 12'd0, 1'b1, 1'b1, 1'b1};
        vecs[7]  = '{16, 4, 1'b0, 12'd0, 12'd0, 1'b1, 1'b1, 1'b1};
        vecs[8]  = '{17, 4, 1'b0, 12'd0, 12'd0, 1'b1, 1'b1, 1'b0};
        vecs[9]  = '{6, 8, 1'b1, 12'd0, 12'd4, 1'b1, 1'b1, 1'b0};
        vecs[10] = '{15, 8, 1'b1, 12'd9, 12'd4, 1'b1, 1'b1, 1'b1};
        vecs[11] = '{16, 8, 1'b0, 12'd0, 12'd0, 1'b1, 1'b1, 1'b1};
        vecs[12] = '{6, 9, 1'b0, 12'd0, 12'd0, 1'b1, 1'b1, 1'b0};
        vecs[13] = '{10, 9, 1'b0, 12'd0, 12'd0, 1'b1, 1'b1, 1'b0};

        rst_s = 1'b0;
        rst_d = 1'b0;
        pix_d = 16'h0000;
        repeat (3) @(negedge clk);
        check_reset_outputs("por");

        rst_s = 1'b1;
        mon_en = 1'b1;

        foreach (vecs[i]) begin
            wait_cyc(1'b0, vecs[i].v * HT + vecs[i].h);
            check($sformatf("vec%0d data_req", i), 32'(req_s), 32'(vecs[i].req));
            check($sformatf("vec%0d xpos", i), 32'(x_s), 32'(vecs[i].x));
            check($sformatf("vec%0d ypos", i), 32'(y_s), 32'(vecs[i].y));
            check($sformatf("vec%0d hsync", i), 32'(hs_s), 32'(vecs[i].hs));
            check($sformatf("vec%0d vsync", i), 32'(vs_s), 32'(vecs[i].vs));
            check($sformatf("vec%0d data_en", i), 32'(en_s), 32'(vecs[i].en));
        end

        wait_cyc(1'b0, FRAME);
        check("first frame_start", 32'(fs_s), 32'd1);

        // Mid-frame reset at line 6, column 10 of the second frame.
        wait_cyc(1'b0, FRAME + 6 * HT + 10);
        mon_en = 1'b0;
        @(posedge clk);
        #2 rst_s = 1'b0;
        #1 check_reset_outputs("async rst");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_reset_outputs($sformatf("rst clk%0d", i));
        end
        sb.delete();
        rst_s = 1'b1;
        mon_en = 1'b1;
        wait_cyc(1'b0, 1);
        check("restart hsync low", 32'(hs_s), 32'd0);
        check("restart no frame_start", 32'(fs_s), 32'd0);

        // Constant white frame: count lit versus dark clocks over one full frame.
        wait_cyc(1'b0, FRAME - 1);
        const_pix = 1'b1;
        n_white = 0;
        n_zero = 0;
        for (int i = 0; i < FRAME; i++) begin
            @(negedge clk);
            if (rgb_s == 16'hFFFF) n_white++;
            else if (rgb_s == 16'h0000) n_zero++;
        end
        check("white clocks", 32'(n_white), 32'd50);
        check("dark clocks", 32'(n_zero), 32'd190);
        mon_en = 1'b0;

        // Default timing: hsync width and period, vsync width, first active line.
        rst_d = 1'b1;
        rise1 = -1;
        rise2 = -1;
        fall = -1;
        prev = hs_d;
        check("dflt hsync at 0", 32'(hs_d), 32'd0);
        for (int i = 0; i < 1300; i++) begin
            @(negedge clk);
            if (!prev && hs_d) begin
                if (rise1 < 0) rise1 = cyc_d;
                else if (rise2 < 0) rise2 = cyc_d;
            end
            if (prev && !hs_d && fall < 0) fall = cyc_d;
            prev = hs_d;
        end
        check("dflt hsync low width", 32'(rise2 - fall), 32'd120);
        check("dflt hsync period", 32'(rise2 - rise1), 32'd1040);

        wait_cyc(1'b1, 6 * 1040 - 1);
        check("dflt vsync low line 5", 32'(vs_d), 32'd0);
        wait_cyc(1'b1, 6 * 1040);
        check("dflt vsync high line 6", 32'(vs_d), 32'd1);

        wait_cyc(1'b1, 29 * 1040 + 183);
        check("dflt h183 data_req", 32'(req_d), 32'd1);
        check("dflt h183 xpos", 32'(x_d), 32'd0);
        check("dflt h183 ypos", 32'(y_d), 32'd0);
        check("dflt h183 data_en", 32'(en_d), 32'd0);
        wait_cyc(1'b1, 29 * 1040 + 982);
        check("dflt h982 data_req", 32'(req_d), 32'd1);
        check("dflt h982 xpos", 32'(x_d), 32'd799);
        wait_cyc(1'b1, 29 * 1040 + 983);
        check("dflt h983 data_req", 32'(req_d), 32'd0);
        check("dflt h983 xpos", 32'(x_d), 32'd0);
        check("dflt h983 data_en", 32'(en_d), 32'd1);
        wait_cyc(1'b1, 29 * 1040 + 984);
        check("dflt h984 data_en", 32'(en_d), 32'd0);
        check("dflt frame_start", 32'(fs_d), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
